// File: rtl/fwd_pkg.sv
// Shared definitions for the EX-stage forwarding/hazard controller: select
// encodings, register-index width and the pipeline stage-record layout.
package fwd_pkg;

    localparam int REG_W = 5;

    typedef logic [REG_W-1:0] reg_idx_t;

    // Operand-mux select driven toward the EX stage; 2'b11 is never produced.
    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_e;

    typedef struct packed {
        logic     valid;
        reg_idx_t rd;
        logic     reg_write;
        logic     mem_read;
    } stage_rec_t;

    // EX additionally remembers its sources.
    typedef struct packed {
        stage_rec_t rec;
        reg_idx_t   rs1;
        reg_idx_t   rs2;
    } ex_rec_t;

    localparam stage_rec_t STAGE_BUBBLE = '0;
    localparam ex_rec_t    EX_BUBBLE    = '0;

endpackage

// File: rtl/fwd_sel_calc.sv
// Priority compare for one source operand: MEM-stage producer beats WB-stage
// producer, and register x0 is never forwarded.
module fwd_sel_calc
    import fwd_pkg::*;
(
    input  logic [REG_W-1:0] rs,
    input  logic             mem_valid,
    input  logic             mem_reg_write,
    input  logic [REG_W-1:0] mem_rd,
    input  logic             wb_valid,
    input  logic             wb_reg_write,
    input  logic [REG_W-1:0] wb_rd,
    output logic [1:0]       sel
);

    logic mem_hit;
    logic wb_hit;

    assign mem_hit = mem_valid && mem_reg_write && (mem_rd != '0) && (mem_rd == rs);
    assign wb_hit  = wb_valid  && wb_reg_write  && (wb_rd  != '0) && (wb_rd  == rs);

    // NOTE: every output of a combinational block gets a default first, so no path can leave it unassigned and infer a latch.
    always_comb begin
        sel = FWD_RF;
        if (mem_hit) begin
            sel = FWD_MEM;
        end else if (wb_hit) begin
            sel = FWD_WB;
        end
    end

endmodule

// File: rtl/forward_ctrl.sv
// Forwarding-select and load-use stall controller tracking EX/MEM/WB records.
// Define FORWARD_CTRL_STATS_EN to build the saturating stall_count counter.
module forward_ctrl
    import fwd_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        id_valid,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic [4:0]  id_rd,
    input  logic        id_reg_write,
    input  logic        id_mem_read,
    input  logic        flush,
    output logic [1:0]  fwd_a_sel,
    output logic [1:0]  fwd_b_sel,
    output logic        stall,
    output logic [15:0] stall_count
);

    ex_rec_t    ex_q;
    stage_rec_t mem_q;
    stage_rec_t wb_q;
    ex_rec_t    id_rec;
    logic [1:0] sel_a_d;
    logic [1:0] sel_b_d;
    logic       load_use;

    always_comb begin
        id_rec.rec.valid     = id_valid;
        id_rec.rec.rd        = id_rd;
        id_rec.rec.reg_write = id_reg_write;
        id_rec.rec.mem_read  = id_mem_read;
        id_rec.rs1           = id_rs1;
        id_rec.rs2           = id_rs2;
    end

    assign load_use = ex_q.rec.valid && ex_q.rec.mem_read && (ex_q.rec.rd != '0)
                   && id_valid && ((id_rs1 == ex_q.rec.rd) || (id_rs2 == ex_q.rec.rd));

    // Reset and redirect both win over the hazard: EX is about to become a bubble anyway.
    assign stall = load_use && !flush && !rst;

    // Current EX becomes MEM and current MEM becomes WB at the edge that loads ID.
    fwd_sel_calc u_sel_a (
        .rs            (id_rs1),
        .mem_valid     (ex_q.rec.valid),
        .mem_reg_write (ex_q.rec.reg_write),
        .mem_rd        (ex_q.rec.rd),
        .wb_valid      (mem_q.valid),
        .wb_reg_write  (mem_q.reg_write),
        .wb_rd         (mem_q.rd),
        .sel           (sel_a_d)
    );

    fwd_sel_calc u_sel_b (
        .rs            (id_rs2),
        .mem_valid     (ex_q.rec.valid),
        .mem_reg_write (ex_q.rec.reg_write),
        .mem_rd        (ex_q.rec.rd),
        .wb_valid      (mem_q.valid),
        .wb_reg_write  (mem_q.reg_write),
        .wb_rd         (mem_q.rd),
        .sel           (sel_b_d)
    );

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_q      <= EX_BUBBLE;
            mem_q     <= STAGE_BUBBLE;
            wb_q      <= STAGE_BUBBLE;
            fwd_a_sel <= FWD_RF;
            fwd_b_sel <= FWD_RF;
        end else begin
            mem_q <= ex_q.rec;
            wb_q  <= mem_q;
            if (flush || stall) begin
                ex_q      <= EX_BUBBLE;
                fwd_a_sel <= FWD_RF;
                fwd_b_sel <= FWD_RF;
            end else begin
                ex_q      <= id_rec;
                fwd_a_sel <= id_valid ? sel_a_d : FWD_RF;
                fwd_b_sel <= id_valid ? sel_b_d : FWD_RF;
            end
        end
    end

    // WB retires on the next edge and EX sources are kept only for visibility.
    logic unused_state;
    assign unused_state = ^{wb_q, mem_q.mem_read, ex_q.rs1, ex_q.rs2};

`ifdef FORWARD_CTRL_STATS_EN
    logic [15:0] stall_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
        end else if (stall && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_q <= stall_cnt_q + 16'd1;
        end
    end

    assign stall_count = stall_cnt_q;
`else
    assign stall_count = '0;
`endif

endmodule
